shift_out: RTL
==============

Name: shift_out

Overview:
- Parallel-to-serial converter: accepts one 512-bit word (e.g. the decrypted RSA result) and streams it out one byte per accepted beat over a valid/ready byte interface.
- Counterpart of the byte-wide input shifter (shiftIn), which assembles 512-bit operands from 8-bit beats.
- Byte order is MSB first, so a shiftIn fed this stream with one byte per clock reassembles the original word.

Parameters:
- WIDTH, 512, parallel word width in bits; must be a multiple of BYTE.
- BYTE, 8, output beat width in bits.
- BEATS (localparam), WIDTH/BYTE = 64, bytes per word; beat counter is clog2(BEATS) bits.

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous reset, active-high
- load_valid  in  1  load_data is valid
- load_ready  out  1  block can accept a word
- load_data  in  WIDTH  word to serialise
- data  out  BYTE  current output byte
- data_valid  out  1  data holds a valid byte
- data_ready  in  1  sink accepts data this cycle
- busy  out  1  a word is being streamed (SHIFT or DONE)
- done  out  1  one-cycle pulse after the last byte is accepted

Behaviour:
- Clocking and reset:
  - Single clock clk; reset rst is synchronous and active-high.
  - While rst is high at an edge: state is IDLE, shift register = 0, beat counter = 0.
  - Reset values: data_valid = 0, data = 0, done = 0, busy = 0, load_ready = 1.
- States: IDLE, SHIFT, DONE.
  - IDLE: load_ready = 1. If load_valid is high at an edge, load_data is captured into the shift register, the counter clears, and the state moves to SHIFT.
  - SHIFT:
    - data_valid = 1 and data = shift register [WIDTH-1 -: BYTE].
    - A beat is accepted on an edge where data_valid && data_ready. On acceptance the register shifts left by BYTE (zero fill) and the counter increments.
    - When the accepted beat has counter == BEATS-1, the state moves to DONE.
  - DONE: done = 1 for exactly one cycle, data_valid = 0, then the state moves to IDLE.
- Output signals:
  - load_ready = (state == IDLE). busy = (state != IDLE).
  - data = 0 whenever data_valid = 0.
- Latency and throughput:
  - Word accepted at edge t0, so data_valid is high in the cycle after t0.
  - With data_ready held high, beats are accepted at edges t1..t64, done is high in the cycle after t64, and load_ready returns the cycle after that.
  - Total occupancy is 66 cycles per word. Throughput is 1 byte/cycle inside a word.
- Backpressure:
  - While data_valid && !data_ready, data, the shift register and the counter hold.
  - data_valid never drops before its beat is accepted.
- load_valid in SHIFT or DONE is ignored: no capture, and in-flight data is not disturbed. The source must hold load_valid until load_ready.
- Reset mid-stream aborts the word immediately, with no done pulse; outputs take their reset values at the next edge.
- rst takes priority over any simultaneous load or beat acceptance.

Test Plan:
- Basic stream:
  - Stimulus: load_data = 0x0102...3F40 (byte k from MSB = k+1), data_ready = 1.
  - Required: data sequence 0x01, 0x02, ..., 0x40 on 64 consecutive cycles starting one cycle after load; done high for exactly one cycle after byte 0x40; load_ready high again the next cycle.
- Backpressure:
  - Stimulus: same word, data_ready toggled 1,0,0,1,... randomly.
  - Required: every byte appears exactly once, in order; data is stable during stall cycles; done asserts only after the 64th accept.
- Load while busy:
  - Stimulus: assert load_valid with 0xFF..FF during byte 10 of a 0x0102...40 stream.
  - Required: stream continues 0x0B, 0x0C, ... unchanged; load_ready stays 0 until after done.
- Reset mid-operation:
  - Stimulus: assert rst for one cycle after byte 20 is accepted.
  - Required: next cycle data_valid = 0, data = 0, busy = 0, load_ready = 1, no done pulse; a new load of 0xA5 repeated then streams 64 × 0xA5 from byte 0.
- Back-to-back words:
  - Stimulus: load_valid held high with word A = all 0x11, then word B = all 0x22.
  - Required: 64 × 0x11, done, one IDLE cycle (B captured), then 64 × 0x22.
- Loopback:
  - Stimulus: data drives shiftIn data with data_ready = 1 and the same clk; word = all ones, then an alternating 0xAA/0x55 pattern.
  - Required: shiftIn outputReg equals the original 512-bit word in the cycle done is high.

Source files
------------

// File: rtl/shift_out.sv
// Parallel-to-serial converter: loads one WIDTH-bit word and streams it MSB byte first
// over a valid/ready byte interface, then pulses done for one cycle.
module shift_out #(
   parameter int WIDTH = 512,
   parameter int BYTE  = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [WIDTH-1:0] load_data,
   output logic [BYTE-1:0]  data,
   output logic             data_valid,
   input  logic             data_ready,
   output logic             busy,
   output logic             done
);

   localparam int BEATS = WIDTH / BYTE;
   localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] sreg;
   logic [CNT_W-1:0] cnt;
   logic             beat;

   // Head of the shift register, forced to zero when no beat is being offered.
   function automatic logic [BYTE-1:0] head_byte(input logic [WIDTH-1:0] r, input logic vld);
      head_byte = vld ? r[WIDTH-1 -: BYTE] : '0;
   endfunction

   assign data_valid = (state == SHIFT);
   assign data       = head_byte(sreg, data_valid);
   assign beat       = data_valid && data_ready;
   assign load_ready = (state == IDLE);
   assign busy       = (state != IDLE);
   assign done       = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE:    if (load_valid) state_nxt = SHIFT;
         SHIFT:   if (beat && (cnt == LAST)) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Capture only in IDLE, so a load request during a stream cannot disturb it.
   always_ff @(posedge clk) begin
      if (rst) begin
         sreg <= '0;
         cnt  <= '0;
      end else if ((state == IDLE) && load_valid) begin
         sreg <= load_data;
         cnt  <= '0;
      end else if (beat) begin
         sreg <= sreg << BYTE;
         cnt  <= cnt + CNT_W'(1);
      end
   end

endmodule
